// File: rtl/alu_ctrl_pipe.sv
// Elastic ALU control decoder: opcode/funct3/funct7 -> 5-bit ALU op through PIPE_DEPTH valid/ready stages.
// Optional macro RV32M_DECODE_EN enables decoding of the M extension (MUL/DIV/REM family).
module alu_ctrl_pipe #(
  parameter int PIPE_DEPTH = 1,
  parameter int ILL_CNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_alu_op,
  output logic                 out_illegal,
  output logic                 out_is_branch,
  output logic                 out_multicyc,
  input  logic                 clr_ill_cnt,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [4:0] ALU_ILLEGAL = 5'b01111;

  logic [4:0] dec_op;
  logic       dec_ill;
  logic       dec_br;
  logic       dec_mc;
  logic [7:0] dec_word;

  always_comb begin
    dec_op  = ALU_ILLEGAL;
    dec_ill = 1'b1;
    unique case (in_opcode)
      OPC_LUI: begin
        dec_op  = 5'b01000;
        dec_ill = 1'b0;
      end
      OPC_AUIPC, OPC_JAL: begin
        dec_op  = 5'b00000;
        dec_ill = 1'b0;
      end
      OPC_JALR: begin
        if (in_funct3 == 3'b000) begin
          dec_op  = 5'b00000;
          dec_ill = 1'b0;
        end
      end
      OPC_LOAD: begin
        if (in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          dec_op  = 5'b00000;
          dec_ill = 1'b0;
        end
      end
      OPC_STORE: begin
        if (in_funct3 inside {3'b000, 3'b001, 3'b010}) begin
          dec_op  = 5'b00000;
          dec_ill = 1'b0;
        end
      end
      OPC_OP: begin
        if (in_funct7 == F7_BASE) begin
          dec_ill = 1'b0;
          case (in_funct3)
            3'b000:  dec_op = 5'b00000;
            3'b001:  dec_op = 5'b01101;
            3'b010:  dec_op = 5'b10110;
            3'b011:  dec_op = 5'b10111;
            3'b100:  dec_op = 5'b00110;
            3'b101:  dec_op = 5'b01010;
            3'b110:  dec_op = 5'b00011;
            default: dec_op = 5'b00010;
          endcase
        end else if (in_funct7 == F7_ALT) begin
          if (in_funct3 == 3'b000) begin
            dec_op  = 5'b00001;
            dec_ill = 1'b0;
          end else if (in_funct3 == 3'b101) begin
            dec_op  = 5'b01011;
            dec_ill = 1'b0;
          end
`ifdef RV32M_DECODE_EN
        end else if (in_funct7 == F7_MEXT) begin
          dec_op  = {2'b11, in_funct3};
          dec_ill = 1'b0;
`endif
        end
      end
      OPC_OPIMM: begin
        dec_ill = 1'b0;
        case (in_funct3)
          3'b000: dec_op = 5'b00000;
          3'b010: dec_op = 5'b10110;
          3'b011: dec_op = 5'b10111;
          3'b100: dec_op = 5'b00110;
          3'b110: dec_op = 5'b00011;
          3'b111: dec_op = 5'b00010;
          3'b001: begin
            if (in_funct7 == F7_BASE) dec_op = 5'b01101;
            else dec_ill = 1'b1;
          end
          default: begin
            if (in_funct7 == F7_BASE) dec_op = 5'b01010;
            else if (in_funct7 == F7_ALT) dec_op = 5'b01011;
            else dec_ill = 1'b1;
          end
        endcase
      end
      OPC_BRANCH: begin
        dec_ill = 1'b0;
        case (in_funct3)
          3'b000:  dec_op = 5'b10000;
          3'b001:  dec_op = 5'b10001;
          3'b100:  dec_op = 5'b10010;
          3'b101:  dec_op = 5'b10011;
          3'b110:  dec_op = 5'b10100;
          3'b111:  dec_op = 5'b10101;
          default: dec_ill = 1'b1;
        endcase
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
    // Partially matched encodings above may have set an op before being rejected.
    if (dec_ill) dec_op = ALU_ILLEGAL;
  end

  assign dec_br = !dec_ill && (dec_op >= 5'b10000) && (dec_op <= 5'b10101);
`ifdef RV32M_DECODE_EN
  assign dec_mc = !dec_ill && (dec_op[4:2] == 3'b111);
`else
  assign dec_mc = 1'b0;
`endif
  assign dec_word = {dec_mc, dec_br, dec_ill, dec_op};

  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic [PIPE_DEPTH-1:0] stage_rdy;
  logic [7:0]            data_q [PIPE_DEPTH];
  logic [7:0]            data_d [PIPE_DEPTH];

  // Stage k is ready if any stage from k to the output is empty or the consumer accepts.
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_rdy
    localparam logic [PIPE_DEPTH-1:0] STAGE_MASK = {PIPE_DEPTH{1'b1}} << k;
    assign stage_rdy[k] = out_ready | ~&(valid_q | ~STAGE_MASK);
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < PIPE_DEPTH; k++) data_d[k] = data_q[k];
    if (stage_rdy[0]) valid_d[0] = in_valid;
    if (in_valid && stage_rdy[0]) data_d[0] = dec_word;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      if (stage_rdy[k]) valid_d[k] = valid_q[k-1];
      if (valid_q[k-1] && stage_rdy[k]) data_d[k] = data_q[k-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_q <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < PIPE_DEPTH; k++) data_q[k] <= data_d[k];
    end
  end

  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (clr_ill_cnt) ill_cnt_d = '0;
    else if (in_valid && stage_rdy[0] && dec_ill && (ill_cnt_q != '1))
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) ill_cnt_q <= '0;
    else ill_cnt_q <= ill_cnt_d;
  end

  assign in_ready      = stage_rdy[0];
  assign out_valid     = valid_q[PIPE_DEPTH-1];
  assign out_alu_op    = data_q[PIPE_DEPTH-1][4:0];
  assign out_illegal   = data_q[PIPE_DEPTH-1][5];
  assign out_is_branch = data_q[PIPE_DEPTH-1][6];
  assign out_multicyc  = data_q[PIPE_DEPTH-1][7];
  assign ill_cnt       = ill_cnt_q;

endmodule
